// File: rtl/uex_mem_resp_pkg.sv
// Shared types and helpers for the uex_mem_resp memory responder.
package uex_mem_resp_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STAT_W = 16;

    // Byte enable for an access of the given size starting at byte lane a.
    function automatic logic [3:0] lane_mask(input logic [1:0] a, input size_e sz);
        logic [3:0] m;
        case (sz)
            SZ_BYTE: m = 4'b0001 << a;
            SZ_HALF: m = 4'b0011 << a;
            SZ_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/uex_mem_resp_ram.sv
// Single-port DEPTH_WORDS x 32 storage with per-byte write enable and registered read.
module uex_mem_resp_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clock,
    input  logic          i_en,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);
    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    // Read-first port; the read register only moves on an access so it holds through RESP.
    always_ff @(posedge clock) begin
        if (i_en) begin
            if (i_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (i_be[b]) begin
                        r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                    end
                end
            end
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/uex_mem_resp.sv
// Single-outstanding memory responder with programmable wait latency and byte/half/word access.
// Define UEX_MEM_RESP_STATS_EN to add saturating read/write/error counters.
module uex_mem_resp
    import uex_mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned LATENCY     = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [1:0]        req_size,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error
`ifdef UEX_MEM_RESP_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_reads,
    output logic [STAT_W-1:0] stat_writes,
    output logic [STAT_W-1:0] stat_errors
`endif
);
    localparam int unsigned AW         = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  CNT_LOAD   = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
    localparam logic        ZERO_LAT   = (LATENCY == 0);

    state_e      r_state, w_state_next;
    logic [3:0]  r_cnt;
    logic        r_alive;
    logic        r_write;
    logic [31:0] r_addr;
    size_e       r_size;
    logic [31:0] r_wdata;
    logic        r_err;

    logic        w_req_fire;
    logic        w_enter_resp;
    logic        w_from_port;
    logic        w_acc_write;
    logic [31:0] w_acc_addr;
    size_e       w_acc_size;
    logic [31:0] w_acc_wdata;
    logic [31:0] w_offset;
    logic        w_misalign;
    logic        w_acc_err;
    logic [AW-1:0] w_word_idx;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_lanes;
    logic [31:0] w_ram_q;
    logic [31:0] w_rd_shift;
    logic [31:0] w_rd_data;

    assign w_req_fire   = req_valid && req_ready;
    assign w_enter_resp = (r_state == IDLE && w_req_fire && ZERO_LAT) ||
                          (r_state == WAIT && r_cnt == 4'd0);

    // With zero latency the access happens on the accept edge, so it must use the live request.
    assign w_from_port = (r_state == IDLE);
    assign w_acc_write = w_from_port ? req_write          : r_write;
    assign w_acc_addr  = w_from_port ? req_addr           : r_addr;
    assign w_acc_size  = w_from_port ? size_e'(req_size)  : r_size;
    assign w_acc_wdata = w_from_port ? req_wdata          : r_wdata;

    always_comb begin
        w_misalign = 1'b0;
        case (w_acc_size)
            SZ_HALF: w_misalign = w_acc_addr[0];
            SZ_WORD: w_misalign = (w_acc_addr[1:0] != 2'b00);
            SZ_ILL:  w_misalign = 1'b1;
            default: w_misalign = 1'b0;
        endcase
    end

    // Range check on the full 32-bit offset; only then is it narrowed to a word index.
    assign w_offset      = w_acc_addr - BASE_ADDR;
    assign w_acc_err     = w_misalign || (w_acc_addr < BASE_ADDR) || (w_offset >= SPAN_BYTES);
    assign w_word_idx    = w_offset[AW+1:2];
    assign w_be          = lane_mask(w_acc_addr[1:0], w_acc_size);
    assign w_wdata_lanes = w_acc_wdata << {w_acc_addr[1:0], 3'b000};

    uex_mem_resp_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clock  (clock),
        .i_en   (w_enter_resp),
        .i_we   (w_acc_write && !w_acc_err),
        .i_be   (w_be),
        .i_addr (w_word_idx),
        .i_wdata(w_wdata_lanes),
        .o_rdata(w_ram_q)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_req_fire) w_state_next = ZERO_LAT ? RESP : WAIT;
            WAIT: if (r_cnt == 4'd0) w_state_next = RESP;
            RESP: if (rsp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_alive <= 1'b0;
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_addr  <= 32'd0;
            r_size  <= SZ_BYTE;
            r_wdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            if (r_state == IDLE && w_req_fire) begin
                r_cnt   <= CNT_LOAD;
                r_write <= req_write;
                r_addr  <= req_addr;
                r_size  <= size_e'(req_size);
                r_wdata <= req_wdata;
            end else if (r_state == WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_resp) begin
                r_err <= w_acc_err;
            end
        end
    end

    always_comb begin
        w_rd_shift = w_ram_q >> {r_addr[1:0], 3'b000};
        case (r_size)
            SZ_BYTE: w_rd_data = {24'd0, w_rd_shift[7:0]};
            SZ_HALF: w_rd_data = {16'd0, w_rd_shift[15:0]};
            default: w_rd_data = w_rd_shift;
        endcase
    end

    always_comb begin
        req_ready = (r_state == IDLE) && r_alive;
        rsp_valid = (r_state == RESP);
        rsp_error = (r_state == RESP) && r_err;
        rsp_rdata = (r_state == RESP && !r_err && !r_write) ? w_rd_data : 32'd0;
    end

`ifdef UEX_MEM_RESP_STATS_EN
    logic [STAT_W-1:0] r_stat_reads, r_stat_writes, r_stat_errors;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stat_reads  <= '0;
            r_stat_writes <= '0;
            r_stat_errors <= '0;
        end else if (w_enter_resp) begin
            if (w_acc_err) begin
                r_stat_errors <= sat_inc(r_stat_errors);
            end else if (w_acc_write) begin
                r_stat_writes <= sat_inc(r_stat_writes);
            end else begin
                r_stat_reads <= sat_inc(r_stat_reads);
            end
        end
    end

    assign stat_reads  = r_stat_reads;
    assign stat_writes = r_stat_writes;
    assign stat_errors = r_stat_errors;
`endif

endmodule

// File: tb/tb_uex_mem_resp.sv
// Bench for uex_mem_resp: three instances (latency 1, 4 and 0) driven by table vectors and a scoreboard.
module tb_uex_mem_resp;
    import uex_mem_resp_pkg::*;

    localparam int          LAT_T   [3] = '{1, 4, 0};
    localparam int          DEPTH_T [3] = '{1024, 1024, 16};
    localparam logic [31:0] BASE_T  [3] = '{32'h0, 32'h0, 32'h1000};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       rstn;
    logic [2:0]       req_valid_a, req_ready_a, rsp_valid_a, rsp_ready_a, rsp_error_a;
    logic [2:0][31:0] rdata_a;
    logic             req_write;
    logic [31:0]      req_addr;
    logic [1:0]       req_size;
    logic [31:0]      req_wdata;
`ifdef UEX_MEM_RESP_STATS_EN
    logic [2:0][15:0] st_rd, st_wr, st_er;
`endif

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        uex_mem_resp #(
            .DEPTH_WORDS(DEPTH_T[gi]),
            .BASE_ADDR  (BASE_T[gi]),
            .LATENCY    (LAT_T[gi])
        ) u_dut (
            .clock    (clk),
            .reset_n  (rstn[gi]),
            .req_valid(req_valid_a[gi]),
            .req_ready(req_ready_a[gi]),
            .req_write(req_write),
            .req_addr (req_addr),
            .req_size (req_size),
            .req_wdata(req_wdata),
            .rsp_valid(rsp_valid_a[gi]),
            .rsp_ready(rsp_ready_a[gi]),
            .rsp_rdata(rdata_a[gi]),
            .rsp_error(rsp_error_a[gi])
`ifdef UEX_MEM_RESP_STATS_EN
            ,
            .stat_reads (st_rd[gi]),
            .stat_writes(st_wr[gi]),
            .stat_errors(st_er[gi])
`endif
        );
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cycles;
    } exp_t;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [1:0]  sz;
        logic [31:0] wd;
        logic [31:0] er;
        logic        ee;
    } vec_t;

    exp_t sb[$];
    int n_pass  = 0;
    int n_total = 0;
    int exp_rd[3] = '{0, 0, 0};
    int exp_wr[3] = '{0, 0, 0};
    int exp_er[3] = '{0, 0, 0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [1:0] sz,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee, input int hold);
        int n;
        logic busy_ok, stable;
        logic [31:0] first;
        exp_t e;
        @(negedge clk);
        req_write = w; req_addr = a; req_size = sz; req_wdata = wd;
        req_valid_a[d] = 1'b1;
        n = 0;
        while (req_ready_a[d] !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (req_ready_a[d] !== 1'b1) begin
            req_valid_a[d] = 1'b0;
            chk("req_ready_timeout", {31'd0, req_ready_a[d]}, 32'd1);
            return;
        end
        sb.push_back('{er, ee, LAT_T[d] + 1});
        @(posedge clk);
        #1;
        req_valid_a[d] = 1'b0;
        n = 0;
        busy_ok = 1'b1;
        @(negedge clk);
        while (rsp_valid_a[d] !== 1'b1 && n < 64) begin
            if (req_ready_a[d] !== 1'b0) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        chk("latency_cycles", 32'(n + 1), 32'(e.cycles));
        first = rdata_a[d];
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            if (rsp_valid_a[d] !== 1'b1 || rdata_a[d] !== first || req_ready_a[d] !== 1'b0)
                stable = 1'b0;
            @(negedge clk);
        end
        if (hold > 0) chk("hold_stable", {31'd0, stable}, 32'd1);
        if (req_ready_a[d] !== 1'b0) busy_ok = 1'b0;
        chk("ready_low_busy", {31'd0, busy_ok}, 32'd1);
        chk("rdata", rdata_a[d], e.rdata);
        chk("error", {31'd0, rsp_error_a[d]}, {31'd0, e.err});
        rsp_ready_a[d] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready_a[d] = 1'b0;
        @(negedge clk);
        chk("rsp_done", {31'd0, rsp_valid_a[d]}, 32'd0);
        if (ee) exp_er[d]++;
        else if (w) exp_wr[d]++;
        else exp_rd[d]++;
        $display("txn dut%0d %s addr=0x%08h size=%0d rdata=0x%08h err=%0b cycles=%0d",
                 d, w ? "WR" : "RD", a, sz, first, rsp_error_a[d], n + 1);
    endtask

    vec_t vt [20];

    initial begin
        int n;
        logic quiet;
        vt[0]  = '{1'b1, 32'h0000_0000, 2'd2, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vt[1]  = '{1'b1, 32'h0000_0010, 2'd2, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vt[2]  = '{1'b0, 32'h0000_0010, 2'd2, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vt[3]  = '{1'b1, 32'h0000_0013, 2'd0, 32'hFFFF_FF5A, 32'h0000_0000, 1'b0};
        vt[4]  = '{1'b0, 32'h0000_0010, 2'd2, 32'h0,         32'h5AAD_BEEF, 1'b0};
        vt[5]  = '{1'b0, 32'h0000_0012, 2'd1, 32'h0,         32'h0000_5AAD, 1'b0};
        vt[6]  = '{1'b0, 32'h0000_0011, 2'd2, 32'h0,         32'h0000_0000, 1'b1};
        vt[7]  = '{1'b0, 32'h0000_0001, 2'd1, 32'h0,         32'h0000_0000, 1'b1};
        vt[8]  = '{1'b0, 32'h0000_0000, 2'd3, 32'h0,         32'h0000_0000, 1'b1};
        vt[9]  = '{1'b0, 32'h0000_1000, 2'd2, 32'h0,         32'h0000_0000, 1'b1};
        vt[10] = '{1'b1, 32'h0000_0011, 2'd2, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vt[11] = '{1'b1, 32'h0000_1000, 2'd0, 32'h0000_00EE, 32'h0000_0000, 1'b1};
        vt[12] = '{1'b0, 32'h0000_0010, 2'd2, 32'h0,         32'h5AAD_BEEF, 1'b0};
        vt[13] = '{1'b0, 32'h0000_0011, 2'd0, 32'h0,         32'h0000_00BE, 1'b0};
        vt[14] = '{1'b0, 32'h0000_0010, 2'd1, 32'h0,         32'h0000_BEEF, 1'b0};
        vt[15] = '{1'b1, 32'h0000_0016, 2'd1, 32'hABCD_CAFE, 32'h0000_0000, 1'b0};
        vt[16] = '{1'b0, 32'h0000_0017, 2'd0, 32'h0,         32'h0000_00CA, 1'b0};
        vt[17] = '{1'b1, 32'h0000_0FFC, 2'd2, 32'h0102_0304, 32'h0000_0000, 1'b0};
        vt[18] = '{1'b0, 32'h0000_0FFF, 2'd0, 32'h0,         32'h0000_0001, 1'b0};
        vt[19] = '{1'b0, 32'hFFFF_FFF0, 2'd2, 32'h0,         32'h0000_0000, 1'b1};

        rstn = 3'b000;
        req_valid_a = '0; rsp_ready_a = '0;
        req_write = 1'b0; req_addr = '0; req_size = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_req_ready", {31'd0, req_ready_a[d]}, 32'd0);
            chk("rst_rsp_valid", {31'd0, rsp_valid_a[d]}, 32'd0);
        end
        chk("rst_rdata", rdata_a[0], 32'd0);
        chk("rst_error", {31'd0, rsp_error_a[0]}, 32'd0);
        rstn = 3'b111;
        #1;
        chk("ready_before_first_edge", {31'd0, req_ready_a[0]}, 32'd0);
        @(negedge clk);
        chk("ready_after_first_edge", {31'd0, req_ready_a[0]}, 32'd1);

        for (int i = 0; i < 20; i++) begin
            txn(0, vt[i].w, vt[i].a, vt[i].sz, vt[i].wd, vt[i].er, vt[i].ee, 0);
        end
        txn(0, 1'b0, 32'h0, 2'd2, 32'h0, 32'h0, 1'b0, 0);

        // Backpressure: response held for five cycles before the initiator takes it.
        txn(0, 1'b0, 32'h10, 2'd2, 32'h0, 32'h5AAD_BEEF, 1'b0, 5);

        // Reset while a latency-4 write is waiting: it must be dropped.
        txn(1, 1'b1, 32'h20, 2'd2, 32'h1234_5678, 32'h0, 1'b0, 0);
`ifdef UEX_MEM_RESP_STATS_EN
        chk("stat_writes_pre_reset", {16'd0, st_wr[1]}, 32'd1);
`endif
        @(negedge clk);
        req_write = 1'b1; req_addr = 32'h20; req_size = 2'd2; req_wdata = 32'h1111_1111;
        req_valid_a[1] = 1'b1;
        n = 0;
        while (req_ready_a[1] !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("wait_accept_ready", {31'd0, req_ready_a[1]}, 32'd1);
        @(posedge clk);
        #1;
        req_valid_a[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("wait_busy_ready", {31'd0, req_ready_a[1]}, 32'd0);
        chk("wait_busy_valid", {31'd0, rsp_valid_a[1]}, 32'd0);
        rstn[1] = 1'b0;
        #1;
        chk("wait_rst_valid", {31'd0, rsp_valid_a[1]}, 32'd0);
`ifdef UEX_MEM_RESP_STATS_EN
        chk("stat_reads_rst", {16'd0, st_rd[1]}, 32'd0);
        chk("stat_writes_rst", {16'd0, st_wr[1]}, 32'd0);
        chk("stat_errors_rst", {16'd0, st_er[1]}, 32'd0);
`endif
        @(negedge clk);
        rstn[1] = 1'b1;
        quiet = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid_a[1] !== 1'b0) quiet = 1'b0;
        end
        chk("no_rsp_after_reset", {31'd0, quiet}, 32'd1);
        txn(1, 1'b0, 32'h20, 2'd2, 32'h0, 32'h1234_5678, 1'b0, 0);

        // Zero latency, non-zero base, 16-word depth.
        txn(2, 1'b1, 32'h1000, 2'd2, 32'hA5A5_A5A5, 32'h0, 1'b0, 0);
        txn(2, 1'b1, 32'h1005, 2'd0, 32'h0000_0077, 32'h0, 1'b0, 0);
        txn(2, 1'b0, 32'h1000, 2'd2, 32'h0, 32'hA5A5_A5A5, 1'b0, 0);
        txn(2, 1'b0, 32'h1005, 2'd0, 32'h0, 32'h0000_0077, 1'b0, 0);
        txn(2, 1'b0, 32'h1000, 2'd1, 32'h0, 32'h0000_A5A5, 1'b0, 0);
        txn(2, 1'b0, 32'h0FFC, 2'd2, 32'h0, 32'h0, 1'b1, 0);

`ifdef UEX_MEM_RESP_STATS_EN
        for (int d = 0; d < 3; d += 2) begin
            chk("stat_reads", {16'd0, st_rd[d]}, 32'(exp_rd[d]));
            chk("stat_writes", {16'd0, st_wr[d]}, 32'(exp_wr[d]));
            chk("stat_errors", {16'd0, st_er[d]}, 32'(exp_er[d]));
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
